// File: rtl/alarm_sequencer_if.sv
// Signal bundle for alarm_sequencer: timekeeper/button inputs and alarm status outputs.
// master drives the time and buttons; slave is the sequencer itself.
interface alarm_sequencer_if;
   logic       tick_1hz;
   logic [4:0] cur_hours;
   logic [5:0] cur_minutes;
   logic [5:0] cur_seconds;
   logic       alarm_en;
   logic       btn_set;
   logic       btn_inc;
   logic       btn_snooze;
   logic       btn_stop;
   logic [4:0] alarm_hours;
   logic [5:0] alarm_minutes;
   logic       buzzer;
   logic [2:0] state;
   logic [2:0] snooze_count;

   modport master (
      output tick_1hz, cur_hours, cur_minutes, cur_seconds, alarm_en,
             btn_set, btn_inc, btn_snooze, btn_stop,
      input  alarm_hours, alarm_minutes, buzzer, state, snooze_count
   );

   modport slave (
      input  tick_1hz, cur_hours, cur_minutes, cur_seconds, alarm_en,
             btn_set, btn_inc, btn_snooze, btn_stop,
      output alarm_hours, alarm_minutes, buzzer, state, snooze_count
   );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm clock sequencer: alarm time entry, arm/ring/snooze control and buzzer drive.
// Ring length, snooze delay and snooze allowance are set by parameters.
module alarm_sequencer #(
   parameter int unsigned SNOOZE_MIN     = 5,
   parameter int unsigned RING_TIMEOUT_S = 60,
   parameter int unsigned MAX_SNOOZE     = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   alarm_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SET_HR  = 3'd1,
      SET_MIN = 3'd2,
      ARMED   = 3'd3,
      RINGING = 3'd4,
      SNOOZE  = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] alarm_hours_q, alarm_hours_d;
   logic [5:0] alarm_minutes_q, alarm_minutes_d;
   logic [2:0] snooze_count_q, snooze_count_d;
   logic [7:0] ring_cnt_q, ring_cnt_d;
   logic [4:0] snz_hours_q, snz_hours_d;
   logic [5:0] snz_minutes_q, snz_minutes_d;
   logic       buzzer_q, buzzer_d;

   logic       sec_zero_tick;
   logic       armed_match;
   logic       snooze_match;
   logic       snooze_ok;
   logic [8:0] ring_inc;
   logic       ring_timeout;
   logic [6:0] min_sum;
   logic [4:0] snz_hr_calc;
   logic [5:0] snz_min_calc;

   assign sec_zero_tick = bus.tick_1hz && (bus.cur_seconds == 6'd0);
   assign armed_match   = sec_zero_tick && (bus.cur_hours == alarm_hours_q)
                          && (bus.cur_minutes == alarm_minutes_q);
   assign snooze_match  = sec_zero_tick && (bus.cur_hours == snz_hours_q)
                          && (bus.cur_minutes == snz_minutes_q);
   assign snooze_ok     = snooze_count_q < 3'(MAX_SNOOZE);
   assign ring_inc      = {1'b0, ring_cnt_q} + 9'd1;
   assign ring_timeout  = ring_inc == 9'(RING_TIMEOUT_S);

   // Snooze target = current time + SNOOZE_MIN, carrying minutes into hours at 60.
   always_comb begin
      min_sum      = {1'b0, bus.cur_minutes} + 7'(SNOOZE_MIN);
      snz_min_calc = min_sum[5:0];
      snz_hr_calc  = bus.cur_hours;
      if (min_sum >= 7'd60) begin
         snz_min_calc = 6'(min_sum - 7'd60);
         snz_hr_calc  = (bus.cur_hours >= 5'd23) ? 5'd0 : bus.cur_hours + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         alarm_hours_q   <= '0;
         alarm_minutes_q <= '0;
         snooze_count_q  <= '0;
         ring_cnt_q      <= '0;
         snz_hours_q     <= '0;
         snz_minutes_q   <= '0;
         buzzer_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         alarm_hours_q   <= alarm_hours_d;
         alarm_minutes_q <= alarm_minutes_d;
         snooze_count_q  <= snooze_count_d;
         ring_cnt_q      <= ring_cnt_d;
         snz_hours_q     <= snz_hours_d;
         snz_minutes_q   <= snz_minutes_d;
         buzzer_q        <= buzzer_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      alarm_hours_d   = alarm_hours_q;
      alarm_minutes_d = alarm_minutes_q;
      snooze_count_d  = snooze_count_q;
      ring_cnt_d      = ring_cnt_q;
      snz_hours_d     = snz_hours_q;
      snz_minutes_d   = snz_minutes_q;
      case (state_q)
         IDLE: begin
            if (bus.btn_set)       state_d = SET_HR;
            else if (bus.alarm_en) state_d = ARMED;
         end
         SET_HR: begin
            if (bus.btn_set)      state_d = SET_MIN;
            else if (bus.btn_inc) alarm_hours_d = (alarm_hours_q >= 5'd23) ? 5'd0 : alarm_hours_q + 5'd1;
         end
         SET_MIN: begin
            if (bus.btn_set)      state_d = IDLE;
            else if (bus.btn_inc) alarm_minutes_d = (alarm_minutes_q >= 6'd59) ? 6'd0 : alarm_minutes_q + 6'd1;
         end
         ARMED: begin
            if (!bus.alarm_en) begin
               state_d        = IDLE;
               snooze_count_d = '0;
            end else if (armed_match) begin
               state_d    = RINGING;
               ring_cnt_d = '0;
            end
         end
         RINGING: begin
            // Priority: disarm, stop, accepted snooze, then second counting/timeout.
            if (!bus.alarm_en) begin
               state_d        = IDLE;
               snooze_count_d = '0;
            end else if (bus.btn_stop) begin
               state_d        = ARMED;
               snooze_count_d = '0;
            end else if (bus.btn_snooze && snooze_ok) begin
               state_d        = SNOOZE;
               snooze_count_d = snooze_count_q + 3'd1;
               snz_hours_d    = snz_hr_calc;
               snz_minutes_d  = snz_min_calc;
            end else if (bus.tick_1hz) begin
               ring_cnt_d = ring_inc[7:0];
               if (ring_timeout) begin
                  state_d        = ARMED;
                  snooze_count_d = '0;
               end
            end
         end
         SNOOZE: begin
            if (!bus.alarm_en) begin
               state_d        = IDLE;
               snooze_count_d = '0;
            end else if (bus.btn_stop) begin
               state_d        = ARMED;
               snooze_count_d = '0;
            end else if (snooze_match) begin
               state_d    = RINGING;
               ring_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      buzzer_d = (state_d == RINGING);
   end

   assign bus.alarm_hours   = alarm_hours_q;
   assign bus.alarm_minutes = alarm_minutes_q;
   assign bus.buzzer        = buzzer_q;
   assign bus.state         = state_q;
   assign bus.snooze_count  = snooze_count_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: minutes-of-day reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_alarm_sequencer;
   localparam int SN = 5;
   localparam int TO = 60;
   localparam int MX = 3;

   logic clk;
   logic rst_n;
   alarm_sequencer_if bus ();

   alarm_sequencer #(
      .SNOOZE_MIN     (SN),
      .RING_TIMEOUT_S (TO),
      .MAX_SNOOZE     (MX)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit run   = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: alarm and snooze targets held as minutes of the day.
   typedef struct {
      int st;
      int ah;
      int am;
      int cnt;
      int ring;
      int tgt;
   } model_t;

   model_t m;

   function automatic model_t next_model(input model_t c);
      model_t n;
      int     now;
      bit     hit;
      n   = c;
      now = int'(bus.cur_hours) * 60 + int'(bus.cur_minutes);
      hit = bus.tick_1hz && (bus.cur_seconds == 6'd0);
      case (c.st)
         0: if (bus.btn_set) n.st = 1; else if (bus.alarm_en) n.st = 3;
         1: if (bus.btn_set) n.st = 2; else if (bus.btn_inc) n.ah = (c.ah + 1) % 24;
         2: if (bus.btn_set) n.st = 0; else if (bus.btn_inc) n.am = (c.am + 1) % 60;
         3: begin
            if (!bus.alarm_en) begin n.st = 0; n.cnt = 0; end
            else if (hit && now == c.ah * 60 + c.am) begin n.st = 4; n.ring = 0; end
         end
         4: begin
            if (!bus.alarm_en) begin n.st = 0; n.cnt = 0; end
            else if (bus.btn_stop) begin n.st = 3; n.cnt = 0; end
            else if (bus.btn_snooze && c.cnt < MX) begin
               n.st = 5; n.cnt = c.cnt + 1; n.tgt = (now + SN) % 1440;
            end else if (bus.tick_1hz) begin
               n.ring = c.ring + 1;
               if (n.ring >= TO) begin n.st = 3; n.cnt = 0; end
            end
         end
         5: begin
            if (!bus.alarm_en) begin n.st = 0; n.cnt = 0; end
            else if (bus.btn_stop) begin n.st = 3; n.cnt = 0; end
            else if (hit && now == c.tgt) begin n.st = 4; n.ring = 0; end
         end
         default: n.st = 0;
      endcase
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '{default: 0};
      else        m <= next_model(m);
   end

   always @(negedge clk) begin
      if (run) begin
         chk("state",         int'(bus.state),         m.st);
         chk("buzzer",        int'(bus.buzzer),        (m.st == 4) ? 1 : 0);
         chk("alarm_hours",   int'(bus.alarm_hours),   m.ah);
         chk("alarm_minutes", int'(bus.alarm_minutes), m.am);
         chk("snooze_count",  int'(bus.snooze_count),  m.cnt);
      end
   end

   task automatic cyc(input logic s, input logic i, input logic z, input logic p, input logic t);
      bus.btn_set    = s;
      bus.btn_inc    = i;
      bus.btn_snooze = z;
      bus.btn_stop   = p;
      bus.tick_1hz   = t;
      @(negedge clk);
      bus.btn_set    = 1'b0;
      bus.btn_inc    = 1'b0;
      bus.btn_snooze = 1'b0;
      bus.btn_stop   = 1'b0;
      bus.tick_1hz   = 1'b0;
   endtask

   task automatic set_time(input int h, input int mi, input int s);
      bus.cur_hours   = 5'(h);
      bus.cur_minutes = 6'(mi);
      bus.cur_seconds = 6'(s);
   endtask

   task automatic tick_at(input int h, input int mi, input int s);
      set_time(h, mi, s);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.alarm_en = 1'b0;
      bus.btn_set = 1'b0; bus.btn_inc = 1'b0; bus.btn_snooze = 1'b0; bus.btn_stop = 1'b0;
      bus.tick_1hz = 1'b0;
      set_time(0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run   = 1'b1;
      chk("reset_state", int'(bus.state), 0);
      chk("reset_buzzer", int'(bus.buzzer), 0);

      // Program 07:30.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (7) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (30) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("prog_hours", int'(bus.alarm_hours), 7);
      chk("prog_minutes", int'(bus.alarm_minutes), 30);
      chk("prog_idle", int'(bus.state), 0);

      // Arm, ring at 07:30:00, auto-stop after 60 ticks.
      bus.alarm_en = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("armed", int'(bus.state), 3);
      tick_at(7, 29, 59);
      chk("no_early_ring", int'(bus.state), 3);
      tick_at(7, 30, 0);
      chk("ring_state", int'(bus.state), 4);
      chk("ring_buzzer", int'(bus.buzzer), 1);
      for (int k = 1; k < TO; k++) tick_at(7, 30, k);
      chk("ring_59_ticks", int'(bus.state), 4);
      tick_at(7, 30, 30);
      chk("timeout_state", int'(bus.state), 3);
      chk("timeout_buzzer", int'(bus.buzzer), 0);

      // Reprogram to 23:58.
      bus.alarm_en = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("disarm_idle", int'(bus.state), 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (16) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (28) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("prog2_hours", int'(bus.alarm_hours), 23);
      chk("prog2_minutes", int'(bus.alarm_minutes), 58);

      // Ring at 23:58, snooze across midnight to 00:03.
      bus.alarm_en = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick_at(23, 58, 0);
      chk("ring2", int'(bus.state), 4);
      set_time(23, 58, 5);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("snooze1_state", int'(bus.state), 5);
      chk("snooze1_count", int'(bus.snooze_count), 1);
      chk("snooze1_buzzer", int'(bus.buzzer), 0);
      tick_at(0, 2, 0);
      chk("snooze_not_yet", int'(bus.state), 5);
      tick_at(0, 3, 0);
      chk("snooze_wrap_ring", int'(bus.state), 4);

      // Use up all snoozes, then the extra snooze is ignored.
      set_time(0, 3, 10);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("snooze2_count", int'(bus.snooze_count), 2);
      tick_at(0, 8, 0);
      chk("snooze2_ring", int'(bus.state), 4);
      set_time(0, 8, 10);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("snooze3_count", int'(bus.snooze_count), 3);
      tick_at(0, 13, 0);
      chk("snooze3_ring", int'(bus.state), 4);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("snooze_max_state", int'(bus.state), 4);
      chk("snooze_max_count", int'(bus.snooze_count), 3);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("stop_wins_state", int'(bus.state), 3);
      chk("stop_wins_count", int'(bus.snooze_count), 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("set_ignored_armed", int'(bus.state), 3);

      // Stop from SNOOZE, then disarm while ringing.
      tick_at(23, 58, 0);
      set_time(23, 58, 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("snooze_again", int'(bus.state), 5);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("stop_in_snooze", int'(bus.state), 3);
      chk("stop_in_snooze_cnt", int'(bus.snooze_count), 0);
      tick_at(23, 58, 0);
      chk("ring3", int'(bus.state), 4);
      bus.alarm_en = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("disarm_ring_state", int'(bus.state), 0);
      chk("disarm_ring_buzzer", int'(bus.buzzer), 0);

      // Hour wrap and simultaneous set+inc.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("hour_wrap", int'(bus.alarm_hours), 0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("set_inc_state", int'(bus.state), 2);
      chk("set_inc_hours", int'(bus.alarm_hours), 0);
      chk("set_inc_minutes", int'(bus.alarm_minutes), 58);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("minute_wrap", int'(bus.alarm_minutes), 0);
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in SET_MIN.
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_state", int'(bus.state), 0);
      chk("async_rst_minutes", int'(bus.alarm_minutes), 0);
      chk("async_rst_hours", int'(bus.alarm_hours), 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.alarm_en = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("first_edge_armed", int'(bus.state), 3);
      repeat (2) @(negedge clk);
      run = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
